imem_responder: RTL and testbench

- Responder side of the instruction-fetch memory interface. Services word reads issued by the fetch stage (address, enable, read_write) and word writes from the program loader.
- Provides a configurable read latency, data hold during stall, and a response-valid strobe. Out-of-range and misaligned accesses are flagged with a sticky fault.
- Sits between the fetch stage and the instruction store. It replaces direct array access so that later fetch work can tolerate multi-cycle memory.

---
 rtl/imem_responder.sv | 119 +++++++++++
 tb/tb_imem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Responder side of the instruction-fetch memory interface. The fetch stage
// issues word reads and the program loader issues word writes. Reads return
// after a fixed, configurable latency with a one-cycle data_valid strobe.
// Out-of-range or misaligned accesses set a sticky fault flag. Faulting reads
// return NOP_WORD, and faulting writes are dropped.
//
// Ports:
//   clock       system clock, all state updates on the rising edge
//   reset       synchronous, active-high; flushes reads, clears outputs/fault
//   address     byte address of the access
//   data_in     write data
//   read_write  0 = read, 1 = write
//   enable      access qualifier; low = stall / no access
//   data_out    read data, holds its value between responses
//   data_valid  one-cycle strobe marking a new response on data_out
//   fault       sticky access-fault flag
//   fault_addr  address of the first faulting access since reset
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        read_write,
    input  logic        enable,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];

    logic [29:0]      word_offset;
    logic [IDX_W-1:0] index;
    logic             in_range;
    logic             aligned;
    logic             access_ok;
    logic             rd_accept;
    logic             wr_accept;
    logic [31:0]      rd_word;

    // Read pipeline: stage 0 is loaded at the accept edge, and the last stage
    // drives the outputs.
    logic [READ_LATENCY-1:0] rd_vld_p;
    logic [31:0]             rd_data_p [READ_LATENCY];

    // Address decode. BASE_ADDR is word aligned, so the subtraction can be done
    // on word addresses. The explicit >= test stops addresses below the base
    // from wrapping around into range.
    always_comb begin
        word_offset = address[31:2] - BASE_ADDR[31:2];
        index       = word_offset[IDX_W-1:0];
        in_range    = (address >= BASE_ADDR) && (word_offset[29:IDX_W] == '0);
        aligned     = (address[1:0] == 2'b00);
        access_ok   = in_range && aligned;
        rd_accept   = enable && !read_write;
        wr_accept   = enable &&  read_write;
        rd_word     = access_ok ? mem[index] : NOP_WORD;
    end

    // Instruction store. Its contents survive reset. Because the array is
    // written at the write edge, a read on the next cycle sees the new data.
    always_ff @(posedge clock) begin
        if (!reset && wr_accept && access_ok) begin
            mem[index] <= data_in;
        end
    end

    // Stage p0 .. p(READ_LATENCY-1): shift register for read responses.
    // Each data stage loads only when its upstream valid is set. The last
    // stage therefore holds its value through stalls and drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld_p <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_data_p[i] <= '0;
            end
        end else begin
            rd_vld_p[0] <= rd_accept;
            if (rd_accept) begin
                rd_data_p[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
                if (rd_vld_p[i-1]) begin
                    rd_data_p[i] <= rd_data_p[i-1];
                end
            end
        end
    end

    assign data_out   = rd_data_p[READ_LATENCY-1];
    assign data_valid = rd_vld_p[READ_LATENCY-1];

    // Sticky fault. Only the first faulting address after reset is kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (enable && !access_ok) begin
            fault <= 1'b1;
            if (!fault) begin
                fault_addr <= address;
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read_write = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;

    logic [31:0] data_out1, data_out3, fault_addr1, fault_addr3;
    logic        data_valid1, data_valid3, fault1, fault3;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clock = ~clock;

    imem_responder #(.READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .address(address), .data_in(data_in),
        .read_write(read_write), .enable(enable), .data_out(data_out1),
        .data_valid(data_valid1), .fault(fault1), .fault_addr(fault_addr1)
    );

    imem_responder #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .address(address), .data_in(data_in),
        .read_write(read_write), .enable(enable), .data_out(data_out3),
        .data_valid(data_valid3), .fault(fault3), .fault_addr(fault_addr3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } resp_t;

    logic [31:0] mmem [int];
    resp_t       q1[$];
    resp_t       q3[$];
    int          edge_n = 0;
    bit          m_started = 0;
    bit          m_vld1 = 0, m_vld3 = 0, m_known1 = 1, m_known3 = 1;
    logic [31:0] m_out1 = '0, m_out3 = '0;
    bit          m_fault = 0;
    logic [31:0] m_faddr = '0;

    always @(posedge clock) begin : model
        longint off;
        bit     ok;
        int     key;
        resp_t  r;
        edge_n++;
        if (reset) begin
            q1.delete();
            q3.delete();
            m_vld1 = 0; m_vld3 = 0;
            m_out1 = '0; m_out3 = '0;
            m_known1 = 1; m_known3 = 1;
            m_fault = 0; m_faddr = '0;
            m_started = 1;
        end else begin
            if (enable) begin
                off = longint'(address) - longint'(BASE);
                ok  = (off >= 0) && (off < longint'(DEPTH) * 4) && (address[1:0] == 2'b00);
                key = int'(off >>> 2);
                if (!read_write) begin
                    if (!ok) begin
                        r.data = NOP; r.known = 1;
                    end else if (mmem.exists(key)) begin
                        r.data = mmem[key]; r.known = 1;
                    end else begin
                        r.data = '0; r.known = 0;
                    end
                    r.due = edge_n;
                    q1.push_back(r);
                    r.due = edge_n + 2;
                    q3.push_back(r);
                end else if (ok) begin
                    mmem[key] = data_in;
                end
                if (!ok) begin
                    if (!m_fault) m_faddr = address;
                    m_fault = 1;
                end
            end
            m_vld1 = 0;
            if (q1.size() > 0 && q1[0].due == edge_n) begin
                r = q1.pop_front();
                m_vld1 = 1; m_out1 = r.data; m_known1 = r.known;
            end
            m_vld3 = 0;
            if (q3.size() > 0 && q3[0].due == edge_n) begin
                r = q3.pop_front();
                m_vld3 = 1; m_out3 = r.data; m_known3 = r.known;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (m_started) begin
            chk("valid_L1", 32'(data_valid1), 32'(m_vld1));
            chk("valid_L3", 32'(data_valid3), 32'(m_vld3));
            if (m_known1) chk("dout_L1", data_out1, m_out1);
            if (m_known3) chk("dout_L3", data_out3, m_out3);
            chk("fault_L1", 32'(fault1), 32'(m_fault));
            chk("fault_L3", 32'(fault3), 32'(m_fault));
            chk("faddr_L1", fault_addr1, m_faddr);
            chk("faddr_L3", fault_addr3, m_faddr);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic rd(input logic [31:0] a);
        enable = 1'b1; read_write = 1'b0; address = a;
        @(negedge clock);
        enable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1; read_write = 1'b1; address = a; data_in = d;
        @(negedge clock);
        enable = 1'b0;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_dout", data_out1, 32'h0);
        chk("rst_valid", 32'(data_valid1), 32'h0);
        chk("rst_fault", 32'(fault1), 32'h0);
        chk("rst_faddr", fault_addr3, 32'h0);

        // loader writes
        wr(32'h0100_0000, 32'hDEAD_BEEF);
        wr(32'h0100_0004, 32'h0050_0093);
        wr(32'h0100_0008, 32'h1111_1111);

        // back-to-back reads, latency 1
        rd(32'h0100_0000);
        chk("b2b_v0", 32'(data_valid1), 32'h1);
        chk("b2b_d0", data_out1, 32'hDEAD_BEEF);
        rd(32'h0100_0004);
        chk("b2b_v1", 32'(data_valid1), 32'h1);
        chk("b2b_d1", data_out1, 32'h0050_0093);
        chk("b2b_fault", 32'(fault1), 32'h0);
        idle(3);

        // read then stall 5 cycles
        rd(32'h0100_0004);
        chk("stall_v", 32'(data_valid1), 32'h1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("stall_hold", data_out1, 32'h0050_0093);
            chk("stall_novalid", 32'(data_valid1), 32'h0);
        end

        // faulting reads: below base, misaligned
        rd(32'h00FF_FFFC);
        chk("flt_rd_low", data_out1, NOP);
        chk("flt_rd_low_v", 32'(data_valid1), 32'h1);
        rd(32'h0100_0002);
        chk("flt_rd_mis", data_out1, NOP);
        chk("flt_flag", 32'(fault1), 32'h1);
        chk("flt_addr", fault_addr1, 32'h00FF_FFFC);

        // out-of-range write dropped, no aliasing onto word 0
        wr(32'h0100_1000, 32'h1234_5678);
        rd(32'h0100_0000);
        chk("oor_wr_d", data_out1, 32'hDEAD_BEEF);
        chk("oor_wr_flt", 32'(fault1), 32'h1);
        chk("oor_wr_addr", fault_addr1, 32'h00FF_FFFC);
        idle(4);

        // latency 3: valid only at N+3
        rd(32'h0100_0000);
        chk("l3_n1", 32'(data_valid3), 32'h0);
        idle(1);
        chk("l3_n2", 32'(data_valid3), 32'h0);
        idle(1);
        chk("l3_n3_v", 32'(data_valid3), 32'h1);
        chk("l3_n3_d", data_out3, 32'hDEAD_BEEF);
        idle(1);
        chk("l3_n4", 32'(data_valid3), 32'h0);
        idle(2);

        // latency 3 with reset at N+1
        rd(32'h0100_0000);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("l3_rst_v", 32'(data_valid3), 32'h0);
        chk("l3_rst_d", data_out3, 32'h0);
        chk("l3_rst_flt", 32'(fault3), 32'h0);
        rd(32'h0100_0000);
        idle(2);
        chk("l3_after_v", 32'(data_valid3), 32'h1);
        chk("l3_after_d", data_out3, 32'hDEAD_BEEF);
        idle(2);

        // write presented during reset is ignored
        reset = 1'b1; enable = 1'b1; read_write = 1'b1;
        address = 32'h0100_0008; data_in = 32'hAAAA_5555;
        @(negedge clock);
        reset = 1'b0; enable = 1'b0;
        rd(32'h0100_0008);
        chk("rst_wr_ign", data_out1, 32'h1111_1111);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
